vx_mem_responder: RTL and testbench

Single-lane memory responder that terminates one cache request/response channel. It sits at the far (slave) end of an arbitrated cache request port, e.g. behind a cache arbiter output or as a local-memory bank. It executes byte-enabled writes and fixed-latency reads against an internal array. It returns responses in order with the request tag echoed unmodified, so upstream arbiters can route them back by embedded select bits.

---
 rtl/vx_mem_responder_pkg.sv | 28 ++
 rtl/vx_fifo_queue.sv | 73 +++++++
 rtl/vx_mem_responder_check.sv | 33 +++
 rtl/vx_mem_responder.sv | 158 +++++++++++++++
 tb/tb_vx_mem_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_mem_responder_pkg.sv
// Shared definitions for the memory responder: address-space constants, default
// configuration, the response payload layout and a parameter sanity helper.
package vx_mem_responder_pkg;

    localparam int XLEN = 32;

    localparam int DEF_DATA_SIZE = 4;
    localparam int DEF_TAG_WIDTH = 8;
    localparam int DEF_SIZE      = 4096;
    localparam int DEF_LATENCY   = 2;
    localparam int DEF_RSP_QUEUE = 4;
    localparam int DEF_WRITE_ACK = 0;

    localparam int ADDR_WIDTH = XLEN - $clog2(DEF_DATA_SIZE);
    localparam int DATA_WIDTH = 8 * DEF_DATA_SIZE;
    localparam int IDX_WIDTH  = $clog2(DEF_SIZE / DEF_DATA_SIZE);
    localparam int RSP_DATAW  = DEF_TAG_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0] tag;
        logic [DATA_WIDTH-1:0]    data;
    } rsp_t;

    function automatic logic is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/vx_fifo_queue.sv
// Response queue with first-word fall-through output: the head entry is visible
// on pop_data whenever the queue is not empty.
module vx_fifo_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] buf_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == CNT_W'(DEPTH));
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign pop_data  = buf_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            buf_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/vx_mem_responder_check.sv
// Parameter legality and queue-overflow checks for the memory responder.
module vx_mem_responder_check
    import vx_mem_responder_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int SIZE      = DEF_SIZE,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int RSP_QUEUE = DEF_RSP_QUEUE
) (
    input logic clk,
    input logic reset,
    input logic push,
    input logic full
);

    if (LATENCY < 1) begin : g_bad_latency
        $error("LATENCY must be >= 1");
    end
    if (RSP_QUEUE < 1) begin : g_bad_queue
        $error("RSP_QUEUE must be >= 1");
    end
    if (!is_pow2(SIZE) || (SIZE < DATA_SIZE)) begin : g_bad_size
        $error("SIZE must be a power of 2 and >= DATA_SIZE");
    end

    // The credit counter must keep the response queue from ever overflowing.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full)) else $error("response queue overflow");
        end
    end

endmodule

// File: rtl/vx_mem_responder.sv
// Single-lane memory responder: byte-enabled writes, fixed-latency reads, and
// in-order responses with the request tag echoed back.
module vx_mem_responder
    import vx_mem_responder_pkg::*;
#(
    parameter int DATA_SIZE  = DEF_DATA_SIZE,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int SIZE       = DEF_SIZE,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int RSP_QUEUE  = DEF_RSP_QUEUE,
    parameter int WRITE_ACK  = DEF_WRITE_ACK,
    localparam int ADDR_W    = XLEN - $clog2(DATA_SIZE),
    localparam int DATA_W    = 8 * DATA_SIZE,
    localparam int IDX_W     = $clog2(SIZE / DATA_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_rw,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_SIZE-1:0] req_byteen,
    input  logic [DATA_W-1:0]    req_data,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_data,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    input  logic                 rsp_ready
);

    localparam int   WORDS   = SIZE / DATA_SIZE;
    localparam int   CNT_W   = $clog2(RSP_QUEUE + 1);
    localparam logic ACK_EN  = (WRITE_ACK != 0);

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [DATA_W-1:0]    data;
    } rsp_entry_t;

    logic [DATA_W-1:0] mem_r [WORDS];
    logic [IDX_W-1:0]  idx_s;
    logic              fire_s;
    logic              need_rsp_s;
    logic              issue_s;
    logic              rsp_fire_s;
    rsp_entry_t        in_entry_s;
    rsp_entry_t        push_entry_s;
    logic              push_valid_s;
    rsp_entry_t        head_s;
    logic              q_empty_s;
    logic              q_full_s;
    logic [CNT_W-1:0]  pending_r;
    logic              unused_addr_s;

    assign idx_s         = req_addr[IDX_W-1:0];
    assign unused_addr_s = ^req_addr[ADDR_W-1:IDX_W];
    assign req_ready     = (pending_r < CNT_W'(RSP_QUEUE));
    assign fire_s        = req_valid & req_ready;
    assign need_rsp_s    = ~req_rw | ACK_EN;
    assign issue_s       = fire_s & need_rsp_s;
    assign rsp_valid     = ~q_empty_s;
    assign rsp_fire_s    = rsp_valid & rsp_ready;
    assign rsp_data      = head_s.data;
    assign rsp_tag       = head_s.tag;

    // Response payload captured at acceptance; write acks carry zero data.
    always_comb begin
        in_entry_s.tag = req_tag;
        if (req_rw) begin
            in_entry_s.data = '0;
        end else begin
            in_entry_s.data = mem_r[idx_s];
        end
    end

    // Byte-enabled array write; the array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (fire_s && req_rw) begin
            for (int b = 0; b < DATA_SIZE; b++) begin
                if (req_byteen[b]) begin
                    mem_r[idx_s][8*b +: 8] <= req_data[8*b +: 8];
                end
            end
        end
    end

    // The queue write is the final latency stage, so only LATENCY-1 registers sit in front of it.
    if (LATENCY == 1) begin : g_no_pipe
        assign push_valid_s = issue_s;
        assign push_entry_s = in_entry_s;
    end else begin : g_pipe
        logic [LATENCY-2:0] valid_r;
        rsp_entry_t         entry_r [LATENCY-1];

        // Valid shift chain, cleared on reset to drop in-flight responses.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_r <= '0;
            end else begin
                valid_r[0] <= issue_s;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    valid_r[k] <= valid_r[k-1];
                end
            end
        end

        // Payload shift chain, qualified by the valid chain.
        always_ff @(posedge clk) begin
            entry_r[0] <= in_entry_s;
            for (int k = 1; k < LATENCY - 1; k++) begin
                entry_r[k] <= entry_r[k-1];
            end
        end

        assign push_valid_s = valid_r[LATENCY-2];
        assign push_entry_s = entry_r[LATENCY-2];
    end

    // Credits cover responses in the pipeline plus the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            case ({issue_s, rsp_fire_s})
                2'b10:   pending_r <= pending_r + CNT_W'(1);
                2'b01:   pending_r <= pending_r - CNT_W'(1);
                default: pending_r <= pending_r;
            endcase
        end
    end

    vx_fifo_queue #(
        .DEPTH (RSP_QUEUE),
        .WIDTH (TAG_WIDTH + DATA_W)
    ) rsp_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_valid_s),
        .push_data (push_entry_s),
        .pop       (rsp_fire_s),
        .pop_data  (head_s),
        .empty     (q_empty_s),
        .full      (q_full_s)
    );

    vx_mem_responder_check #(
        .DATA_SIZE (DATA_SIZE),
        .SIZE      (SIZE),
        .LATENCY   (LATENCY),
        .RSP_QUEUE (RSP_QUEUE)
    ) checks (
        .clk   (clk),
        .reset (reset),
        .push  (push_valid_s),
        .full  (q_full_s)
    );

endmodule

// File: tb/tb_vx_mem_responder.sv
// Scoreboard bench: dut_a uses the default configuration, dut_b has write acks
// enabled and a queue of exactly LATENCY+1 entries.
module tb_vx_mem_responder;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          a_req_valid, a_req_rw, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [AW-1:0] a_req_addr;
    logic [3:0]    a_req_byteen;
    logic [DW-1:0] a_req_data, a_rsp_data;
    logic [TW-1:0] a_req_tag, a_rsp_tag;
    logic          b_req_valid, b_req_rw, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [AW-1:0] b_req_addr;
    logic [3:0]    b_req_byteen;
    logic [DW-1:0] b_req_data, b_rsp_data;
    logic [TW-1:0] b_req_tag, b_rsp_tag;

    vx_mem_responder dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_rw(a_req_rw), .req_addr(a_req_addr),
        .req_byteen(a_req_byteen), .req_data(a_req_data), .req_tag(a_req_tag),
        .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
        .rsp_tag(a_rsp_tag), .rsp_ready(a_rsp_ready)
    );

    vx_mem_responder #(.WRITE_ACK(1), .RSP_QUEUE(3)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_rw(b_req_rw), .req_addr(b_req_addr),
        .req_byteen(b_req_byteen), .req_data(b_req_data), .req_tag(b_req_tag),
        .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
        .rsp_tag(b_rsp_tag), .rsp_ready(b_rsp_ready)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int acc_a  = 0;
    int acc_b  = 0;
    logic [DW-1:0] mdl_a [int];
    logic [DW-1:0] mdl_b [int];
    logic [39:0]   exp_a [$];
    logic [39:0]   got_a [$];
    logic [39:0]   exp_b [$];
    logic [39:0]   got_b [$];
    int            cyc_b [$];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // One clock: capture responses and model accepted requests at the falling edge.
    task automatic tick();
        int ia;
        int ib;
        logic [31:0] old_w;
        @(negedge clk);
        if (a_rsp_valid && a_rsp_ready) got_a.push_back({a_rsp_tag, a_rsp_data});
        if (b_rsp_valid && b_rsp_ready) begin
            got_b.push_back({b_rsp_tag, b_rsp_data});
            cyc_b.push_back(cycle);
        end
        if (a_req_valid && a_req_ready && !reset) begin
            acc_a++;
            ia = int'(a_req_addr[9:0]);
            old_w = mdl_a.exists(ia) ? mdl_a[ia] : 32'h0;
            if (a_req_rw) mdl_a[ia] = merge(old_w, a_req_data, a_req_byteen);
            else          exp_a.push_back({a_req_tag, old_w});
        end
        if (b_req_valid && b_req_ready && !reset) begin
            acc_b++;
            ib = int'(b_req_addr[9:0]);
            old_w = mdl_b.exists(ib) ? mdl_b[ib] : 32'h0;
            if (b_req_rw) begin
                mdl_b[ib] = merge(old_w, b_req_data, b_req_byteen);
                exp_b.push_back({b_req_tag, 32'h0});
            end else begin
                exp_b.push_back({b_req_tag, old_w});
            end
        end
        @(posedge clk);
        cycle++;
        #1;
    endtask

    task automatic clear_queues();
        exp_a.delete(); got_a.delete(); exp_b.delete(); got_b.delete(); cyc_b.delete();
    endtask

    task automatic send_a(input logic rw, input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic [7:0] tag);
        int start;
        int n;
        start = acc_a;
        n = 0;
        a_req_valid = 1'b1; a_req_rw = rw; a_req_addr = addr;
        a_req_data = data; a_req_byteen = be; a_req_tag = tag;
        while (acc_a == start && n < 50) begin tick(); n++; end
        a_req_valid = 1'b0;
        checks++;
        if (acc_a == start) begin errors++; $display("FAIL send_a accept timeout tag=%0h", tag); end
    endtask

    task automatic send_b(input logic rw, input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic [7:0] tag);
        int start;
        int n;
        start = acc_b;
        n = 0;
        b_req_valid = 1'b1; b_req_rw = rw; b_req_addr = addr;
        b_req_data = data; b_req_byteen = be; b_req_tag = tag;
        while (acc_b == start && n < 50) begin tick(); n++; end
        b_req_valid = 1'b0;
        checks++;
        if (acc_b == start) begin errors++; $display("FAIL send_b accept timeout tag=%0h", tag); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_req_valid = 1'b0; a_req_rw = 1'b0; a_req_addr = '0; a_req_byteen = '0;
        a_req_data = '0; a_req_tag = '0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_rw = 1'b0; b_req_addr = '0; b_req_byteen = '0;
        b_req_data = '0; b_req_tag = '0; b_rsp_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks += 4;
        if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_a_rsp_valid got=%b exp=0", a_rsp_valid); end
        if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_a_req_ready got=%b exp=1", a_req_ready); end
        if (b_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_b_rsp_valid got=%b exp=0", b_rsp_valid); end
        if (b_req_ready !== 1'b1) begin errors++; $display("FAIL reset_b_req_ready got=%b exp=1", b_req_ready); end
    endtask

    task automatic test_write_read();
        int n;
        logic [39:0] g;
        logic [39:0] e;
        clear_queues();
        a_rsp_ready = 1'b1;
        send_a(1'b1, 30'd5, 32'hDEADBEEF, 4'hF, 8'h01);
        send_a(1'b0, 30'd5, 32'h0, 4'h0, 8'h3A);
        n = 0;
        while (got_a.size() == 0 && n < 20) begin tick(); n++; end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL read_latency got=%0d exp=2", n); end
        repeat (4) tick();
        checks++;
        if (got_a.size() !== 1) begin
            errors++; $display("FAIL wr_rd_rsp_count got=%0d exp=1", got_a.size());
        end
        if (got_a.size() > 0 && exp_a.size() > 0) begin
            g = got_a.pop_front();
            e = exp_a.pop_front();
            checks += 3;
            if (g[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data got=%h exp=deadbeef", g[31:0]); end
            if (g[39:32] !== 8'h3A) begin errors++; $display("FAIL wr_rd_tag got=%h exp=3a", g[39:32]); end
            if (g !== e) begin errors++; $display("FAIL wr_rd_model got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_byteen();
        int n;
        logic [39:0] g;
        clear_queues();
        send_a(1'b1, 30'd9, 32'h11223344, 4'hF, 8'h02);
        send_a(1'b1, 30'd9, 32'hAABBCCDD, 4'b0101, 8'h03);
        send_a(1'b0, 30'd9, 32'h0, 4'hF, 8'h3B);
        n = 0;
        while (got_a.size() == 0 && n < 20) begin tick(); n++; end
        checks++;
        if (got_a.size() == 0) begin
            errors++; $display("FAIL byteen_rsp_timeout got=0 exp=1");
        end else begin
            g = got_a.pop_front();
            checks += 2;
            if (g[31:0] !== 32'h11BB33DD) begin errors++; $display("FAIL byteen_data got=%h exp=11bb33dd", g[31:0]); end
            if (g[39:32] !== 8'h3B) begin errors++; $display("FAIL byteen_tag got=%h exp=3b", g[39:32]); end
        end
    endtask

    task automatic test_backpressure();
        int base;
        int n;
        clear_queues();
        a_rsp_ready = 1'b0;
        base = acc_a;
        a_req_valid = 1'b1; a_req_rw = 1'b0; a_req_byteen = 4'h0; a_req_data = '0;
        for (int i = 0; i < 8; i++) begin
            a_req_tag  = 8'(acc_a - base);
            a_req_addr = ((acc_a - base) % 2 == 1) ? 30'd9 : 30'd5;
            tick();
        end
        a_req_valid = 1'b0;
        checks += 2;
        if (acc_a - base !== 4) begin errors++; $display("FAIL bp_accepts got=%0d exp=4", acc_a - base); end
        if (a_req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got=%b exp=0", a_req_ready); end
        a_rsp_ready = 1'b1;
        tick();
        checks++;
        if (a_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return got=%b exp=1", a_req_ready); end
        n = 0;
        while (got_a.size() < 4 && n < 20) begin tick(); n++; end
        checks++;
        if (got_a.size() !== 4 || exp_a.size() !== 4) begin
            errors++; $display("FAIL bp_drain_count got=%0d exp=4", got_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (got_a[i][39:32] !== 8'(i)) begin errors++; $display("FAIL bp_tag[%0d] got=%h exp=%h", i, got_a[i][39:32], 8'(i)); end
                if (got_a[i] !== exp_a[i]) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_a[i], exp_a[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int ready_low;
        clear_queues();
        b_rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_b(1'b1, 30'(64 + i), $urandom, 4'hF, 8'(i));
        n = 0;
        while (got_b.size() < 16 && n < 40) begin tick(); n++; end
        checks++;
        if (got_b.size() !== 16) begin errors++; $display("FAIL b2b_prewrite_acks got=%0d exp=16", got_b.size()); end
        clear_queues();
        ready_low = 0;
        b_req_valid = 1'b1; b_req_rw = 1'b0; b_req_byteen = 4'h0; b_req_data = '0;
        for (int i = 0; i < 16; i++) begin
            b_req_addr = 30'(64 + i);
            b_req_tag  = 8'(8'h20 + i);
            if (b_req_ready !== 1'b1) ready_low++;
            tick();
        end
        b_req_valid = 1'b0;
        checks++;
        if (ready_low !== 0) begin errors++; $display("FAIL b2b_ready_drops got=%0d exp=0", ready_low); end
        n = 0;
        while (got_b.size() < 16 && n < 30) begin tick(); n++; end
        checks++;
        if (got_b.size() !== 16 || exp_b.size() !== 16) begin
            errors++; $display("FAIL b2b_rsp_count got=%0d exp=16", got_b.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks += 3;
                if (got_b[i][39:32] !== 8'(8'h20 + i)) begin errors++; $display("FAIL b2b_tag[%0d] got=%h exp=%h", i, got_b[i][39:32], 8'(8'h20 + i)); end
                if (got_b[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_b[i], exp_b[i]); end
                if (cyc_b[i] !== cyc_b[0] + i) begin errors++; $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", i, cyc_b[i], cyc_b[0] + i); end
            end
        end
    endtask

    task automatic test_write_ack();
        int n;
        logic [39:0] g;
        logic [7:0]  tags [4];
        logic [31:0] datas [4];
        tags  = '{8'h10, 8'h11, 8'h12, 8'h13};
        datas = '{32'h12345678, 32'h0, 32'hCAFEF00D, 32'h0};
        clear_queues();
        b_rsp_ready = 1'b1;
        send_b(1'b1, 30'd3, 32'h12345678, 4'hF, 8'h07);
        n = 0;
        while (got_b.size() == 0 && n < 20) begin tick(); n++; end
        checks++;
        if (got_b.size() == 0) begin
            errors++; $display("FAIL wack_timeout got=0 exp=1");
        end else begin
            g = got_b.pop_front();
            checks += 2;
            if (g[31:0] !== 32'h0) begin errors++; $display("FAIL wack_data got=%h exp=0", g[31:0]); end
            if (g[39:32] !== 8'h07) begin errors++; $display("FAIL wack_tag got=%h exp=07", g[39:32]); end
        end
        clear_queues();
        send_b(1'b0, 30'd3, 32'h0, 4'hF, 8'h10);
        send_b(1'b1, 30'd4, 32'hCAFEF00D, 4'hF, 8'h11);
        send_b(1'b0, 30'd4, 32'h0, 4'hF, 8'h12);
        send_b(1'b1, 30'd3, 32'h0, 4'b0011, 8'h13);
        n = 0;
        while (got_b.size() < 4 && n < 30) begin tick(); n++; end
        checks++;
        if (got_b.size() !== 4) begin
            errors++; $display("FAIL mix_count got=%0d exp=4", got_b.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (got_b[i][39:32] !== tags[i]) begin errors++; $display("FAIL mix_tag[%0d] got=%h exp=%h", i, got_b[i][39:32], tags[i]); end
                if (got_b[i][31:0] !== datas[i]) begin errors++; $display("FAIL mix_data[%0d] got=%h exp=%h", i, got_b[i][31:0], datas[i]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int base;
        int n;
        clear_queues();
        a_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_a(1'b0, 30'd5, 32'h0, 4'h0, 8'(8'h40 + i));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 2;
        if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        if (a_req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_req_ready got=%b exp=1", a_req_ready); end
        clear_queues();
        base = acc_a;
        a_req_valid = 1'b1; a_req_rw = 1'b0; a_req_addr = 30'd5;
        for (int i = 0; i < 6; i++) begin
            a_req_tag = 8'(acc_a - base);
            tick();
        end
        a_req_valid = 1'b0;
        checks++;
        if (acc_a - base !== 4) begin errors++; $display("FAIL mid_reset_credits got=%0d exp=4", acc_a - base); end
        a_rsp_ready = 1'b1;
        n = 0;
        while (got_a.size() < 4 && n < 20) begin tick(); n++; end
        checks++;
        if (got_a.size() !== 4) begin
            errors++; $display("FAIL mid_reset_drain got=%0d exp=4", got_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (got_a[i][31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_reset_data[%0d] got=%h exp=deadbeef", i, got_a[i][31:0]); end
                if (got_a[i][39:32] !== 8'(i)) begin errors++; $display("FAIL mid_reset_tag[%0d] got=%h exp=%h", i, got_a[i][39:32], 8'(i)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteen();
        test_backpressure();
        test_back_to_back();
        test_write_ack();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

endmodule
